// File: rtl/and_or_array_pkg.sv
// Shared definitions for the and_or_array block.
//   state_t : control FSM states (RUN, DRAIN, CFG)
//   addr_w  : width of a select field addressing n items, never below 1 bit
package and_or_array_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CFG   = 2'd2
    } state_t;

    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/and_or_array_if.sv
// Stream + config bus of the and_or_array block.
//   in_valid/in_ready/in_data    : input vector stream
//   out_valid/out_ready/out_data : per-channel result stream
//   cfg_valid/cfg_ready/cfg_ch/cfg_term/cfg_mask : mask write port
//   cfg_inv : per-channel invert bit, only with AND_OR_ARRAY_INV_EN
// Modports: master = stimulus/checker side, slave = the array.
interface and_or_array_if
    import and_or_array_pkg::*;
#(
    parameter int N_IN    = 10,
    parameter int N_CH    = 2,
    parameter int N_TERMS = 2
) ();
    localparam int CH_W   = addr_w(N_CH);
    localparam int TERM_W = addr_w(N_TERMS);

    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_CH-1:0]   out_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [TERM_W-1:0] cfg_term;
    logic [N_IN-1:0]   cfg_mask;
`ifdef AND_OR_ARRAY_INV_EN
    logic              cfg_inv;
`endif

    modport master (
        output in_valid, in_data, out_ready, cfg_valid, cfg_ch, cfg_term, cfg_mask,
`ifdef AND_OR_ARRAY_INV_EN
        output cfg_inv,
`endif
        input  in_ready, out_valid, out_data, cfg_ready
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_valid, cfg_ch, cfg_term, cfg_mask,
`ifdef AND_OR_ARRAY_INV_EN
        input  cfg_inv,
`endif
        output in_ready, out_valid, out_data, cfg_ready
    );

endinterface

// File: rtl/and_or_array_cfg.sv
// Mask register file of the and_or_array block (plus per-channel invert
// bits when AND_OR_ARRAY_INV_EN is defined).
//   clk, reset      : clock, synchronous active-high reset (clears all)
//   wr_en           : perform a write this cycle
//   wr_ch, wr_term  : target channel / term; out-of-range writes are dropped
//   wr_mask         : new mask for that term
//   wr_inv          : new invert bit for channel wr_ch (INV_EN only)
//   mask            : all masks, entry index = ch*N_TERMS + term
//   inv             : per-channel invert bits (INV_EN only)
module and_or_array_cfg
    import and_or_array_pkg::*;
#(
    parameter int N_IN    = 10,
    parameter int N_CH    = 2,
    parameter int N_TERMS = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [addr_w(N_CH)-1:0]              wr_ch,
    input  logic [addr_w(N_TERMS)-1:0]           wr_term,
    input  logic [N_IN-1:0]                      wr_mask,
`ifdef AND_OR_ARRAY_INV_EN
    input  logic                                 wr_inv,
    output logic [N_CH-1:0]                      inv,
`endif
    output logic [N_CH*N_TERMS-1:0][N_IN-1:0]    mask
);
    localparam int N_T = N_CH * N_TERMS;

    logic wr_ok;
    int   wr_idx;

    // Select fields are power-of-two wide, so they can name channels/terms
    // that do not exist; such writes complete but change nothing.
    assign wr_ok  = wr_en && (int'(wr_ch) < N_CH) && (int'(wr_term) < N_TERMS);
    assign wr_idx = int'(wr_ch) * N_TERMS + int'(wr_term);

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
`ifdef AND_OR_ARRAY_INV_EN
            inv  <= '0;
`endif
        end else if (wr_ok) begin
            for (int k = 0; k < N_T; k++) begin
                if (k == wr_idx) mask[k] <= wr_mask;
            end
`ifdef AND_OR_ARRAY_INV_EN
            for (int c = 0; c < N_CH; c++) begin
                if (c == int'(wr_ch)) inv[c] <= wr_inv;
            end
`endif
        end
    end

endmodule

// File: rtl/and_or_array.sv
// Pipelined, runtime-programmable AND-OR array.
//   clk   : clock, all logic on rising edge
//   reset : synchronous active-high reset
//   bus   : and_or_array_if.slave (input stream, output stream, cfg port)
// out_data[c] = OR over terms t of (&(in_data | ~mask[c][t])), a term with
// an all-zero mask contributing 0. Two-stage pipeline: stage 1 holds term
// bits, stage 2 holds per-channel ORs. Config writes first drain the pipe so
// a vector always sees the masks present when it entered stage 1.
// Optional: AND_OR_ARRAY_INV_EN adds per-channel output inversion.
module and_or_array
    import and_or_array_pkg::*;
#(
    parameter int N_IN    = 10,
    parameter int N_CH    = 2,
    parameter int N_TERMS = 2
) (
    input  logic          clk,
    input  logic          reset,
    and_or_array_if.slave bus
);
    localparam int N_T = N_CH * N_TERMS;

    state_t                      state;
    logic                        adv;
    logic                        accept;
    logic                        cfg_we;
    logic                        vld_p1;
    logic                        vld_p2;
    logic [N_T-1:0][N_IN-1:0]    mask;
    logic [N_T-1:0]              term_now;
    logic [N_T-1:0]              term_p1;
    logic [N_CH-1:0]             or_now;
    logic [N_CH-1:0]             out_p2;
`ifdef AND_OR_ARRAY_INV_EN
    logic [N_CH-1:0]             inv;
    logic [N_CH-1:0]             inv_p1;
`endif

    and_or_array_cfg #(
        .N_IN    (N_IN),
        .N_CH    (N_CH),
        .N_TERMS (N_TERMS)
    ) u_cfg (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cfg_we),
        .wr_ch   (bus.cfg_ch),
        .wr_term (bus.cfg_term),
        .wr_mask (bus.cfg_mask),
`ifdef AND_OR_ARRAY_INV_EN
        .wr_inv  (bus.cfg_inv),
        .inv     (inv),
`endif
        .mask    (mask)
    );

    // Both stages freeze only while a result waits on the consumer.
    assign adv    = !(vld_p2 && !bus.out_ready);
    // A pending config request blocks new input in the same cycle.
    assign bus.in_ready  = !reset && (state == RUN) && !bus.cfg_valid && adv;
    assign bus.cfg_ready = !reset && (state == CFG);
    assign accept = bus.in_valid && bus.in_ready;
    assign cfg_we = bus.cfg_valid && bus.cfg_ready;

    assign bus.out_valid = vld_p2;
    assign bus.out_data  = out_p2;

    // Zero mask disables the term instead of making it constant 1.
    always_comb begin
        term_now = '0;
        for (int k = 0; k < N_T; k++) begin
            term_now[k] = (|mask[k]) & (&(bus.in_data | ~mask[k]));
        end
    end

    always_comb begin
        or_now = '0;
        for (int c = 0; c < N_CH; c++) begin
            or_now[c] = |term_p1[c*N_TERMS +: N_TERMS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (bus.cfg_valid) state <= DRAIN;
                DRAIN:   if (!bus.cfg_valid)        state <= RUN;
                         else if (!vld_p1 && !vld_p2) state <= CFG;
                CFG:     if (!bus.cfg_valid) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            out_p2 <= '0;
        end else if (adv) begin
            // stage 1: term capture
            vld_p1 <= accept;
            if (accept) begin
                term_p1 <= term_now;
`ifdef AND_OR_ARRAY_INV_EN
                inv_p1  <= inv;
`endif
            end
            // stage 2: per-channel OR
            vld_p2 <= vld_p1;
            if (vld_p1) begin
`ifdef AND_OR_ARRAY_INV_EN
                out_p2 <= or_now ^ inv_p1;
`else
                out_p2 <= or_now;
`endif
            end
        end
    end

endmodule

// File: tb/tb_and_or_array.sv
module tb_and_or_array;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    and_or_array_if #(.N_IN(10), .N_CH(2), .N_TERMS(2)) bus ();
    and_or_array #(.N_IN(10), .N_CH(2), .N_TERMS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance with non-power-of-two sizes so out-of-range
    // channel/term selects are representable.
    and_or_array_if #(.N_IN(10), .N_CH(3), .N_TERMS(3)) bus3 ();
    and_or_array #(.N_IN(10), .N_CH(3), .N_TERMS(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          base;
    bit          use7458 = 1'b0;
    logic [1:0]  sb_q[$];
    logic [9:0]  mdl_mask [2][2];
    logic [1:0]  mdl_inv;

    function automatic logic [1:0] gold7458(input logic [9:0] d);
        logic [1:0] y;
        y[0] = (d[0] & d[1] & d[2]) | (d[3] & d[4] & d[5]);
        y[1] = (d[6] & d[7]) | (d[8] & d[9]);
        return y;
    endfunction

    function automatic logic [1:0] model(input logic [9:0] d);
        logic [1:0] orv;
        bit any, all;
        orv = 2'b00;
        for (int c = 0; c < 2; c++) begin
            for (int t = 0; t < 2; t++) begin
                any = 1'b0;
                all = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    if (mdl_mask[c][t][i]) begin
                        any = 1'b1;
                        if (!d[i]) all = 1'b0;
                    end
                end
                if (any && all) orv[c] = 1'b1;
            end
        end
        return orv ^ mdl_inv;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb_q.delete();
        mdl_inv = 2'b00;
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 2; t++) mdl_mask[c][t] = 10'h000;
    endtask

    task automatic send(input logic [9:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) timeout("send");
        tick();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int term, input logic [9:0] m, input logic iv);
        int n;
        n = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 1'(ch);
        bus.cfg_term  = 1'(term);
        bus.cfg_mask  = m;
`ifdef AND_OR_ARRAY_INV_EN
        bus.cfg_inv   = iv;
`endif
        @(negedge clk);
        while (!bus.cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cfg_ready) timeout("cfg_write");
        tick();
        mdl_mask[ch][term] = m;
`ifdef AND_OR_ARRAY_INV_EN
        mdl_inv[ch] = iv;
`endif
    endtask

    task automatic cfg_end();
        bus.cfg_valid = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) timeout("drain");
        tick();
    endtask

    // Scoreboard: pop/compare on every output handshake, push the
    // expected result on every input handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected: observed %0h expected no output", bus.out_data);
                end
                if (sb_q.size() != 0) check("sb_data", bus.out_data, sb_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                sb_q.push_back(use7458 ? gold7458(bus.in_data) : model(bus.in_data));
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_ch = '0;   bus.cfg_term = '0;  bus.cfg_mask = '0;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b1;
        bus3.cfg_valid = 1'b0; bus3.cfg_ch = '0; bus3.cfg_term = '0; bus3.cfg_mask = '0;
`ifdef AND_OR_ARRAY_INV_EN
        bus.cfg_inv = 1'b0;
        bus3.cfg_inv = 1'b0;
`endif
        clear_model();
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // 7458 function as four mask loads, then one vector with latency check
        cfg_write(0, 0, 10'h007, 1'b0);
        cfg_write(0, 1, 10'h038, 1'b0);
        cfg_write(1, 0, 10'h0C0, 1'b0);
        cfg_write(1, 1, 10'h300, 1'b0);
        cfg_end();
        send(10'h007);
        idle();
        @(negedge clk);
        check("lat_cycle1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", bus.out_valid, 1);
        check("lat_cycle2_data",  bus.out_data,  2'b01);
        wait_drain();

        // exhaustive back-to-back stream against the 7458 golden model
        use7458 = 1'b1;
        base = n_out;
        for (int d = 0; d < 1024; d++) send(10'(d));
        idle();
        wait_drain();
        use7458 = 1'b0;
        check("stream_count", n_out - base, 1024);

        // backpressure: third vector held off, result frozen
        base = n_out;
        bus.out_ready = 1'b0;
        send(10'h007);
        send(10'h0C0);
        bus.in_valid = 1'b1;
        bus.in_data  = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready",  bus.in_ready,  0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_data",  bus.out_data,  2'b01);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(10'h3FF);
        idle();
        wait_drain();
        check("stall_count", n_out - base, 3);

        // config request while streaming: drain first, then write
        send(10'h007);
        send(10'h038);
        bus.in_data   = 10'h001;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 1'b0;
        bus.cfg_term  = 1'b0;
        bus.cfg_mask  = 10'h001;
        @(negedge clk);
        check("cfg_blocks_input", bus.in_ready, 0);
        n = 0;
        while (!bus.cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cfg_ready) timeout("cfg_ready");
        check("drained_before_cfg", sb_q.size(), 0);
        @(posedge clk); #1;
        mdl_mask[0][0] = 10'h001;
        bus.cfg_valid = 1'b0;
        send(10'h001);
        idle();
        wait_drain();

        // request withdrawn during DRAIN: no write may happen
        send(10'h038);
        idle();
        bus.cfg_valid = 1'b1;
        bus.cfg_mask  = 10'h3FF;
        tick();
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        check("drain_abort_cfg_ready", bus.cfg_ready, 0);
        tick();
        send(10'h001);
        idle();
        wait_drain();

`ifdef AND_OR_ARRAY_INV_EN
        // AND-OR-INVERT on channel 0
        cfg_write(0, 0, 10'h007, 1'b1);
        cfg_end();
        send(10'h000);
        idle();
        wait_drain();
`endif

        // out-of-range selects on the 3x3 instance are dropped
        bus3.cfg_valid = 1'b1;
        bus3.cfg_ch = 2'd0; bus3.cfg_term = 2'd0; bus3.cfg_mask = 10'h001;
        n = 0;
        @(negedge clk);
        while (!bus3.cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus3.cfg_ready) timeout("cfg3_ready");
        tick();
        bus3.cfg_ch = 2'd1; bus3.cfg_term = 2'd3; bus3.cfg_mask = 10'h002;
        tick();
        bus3.cfg_ch = 2'd3; bus3.cfg_term = 2'd0; bus3.cfg_mask = 10'h004;
        tick();
        bus3.cfg_ch = 2'd1; bus3.cfg_term = 2'd2; bus3.cfg_mask = 10'h200;
        tick();
        bus3.cfg_valid = 1'b0;
        tick();
        bus3.in_valid = 1'b1;
        bus3.in_data  = 10'h3FF;
        n = 0;
        @(negedge clk);
        while (!bus3.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus3.in_ready) timeout("send3");
        tick();
        bus3.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus3.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus3.out_valid) timeout("out3");
        check("range_drop", bus3.out_data, 3'b011);

        // reset with vectors in flight, then zero masks give zero output
        send(10'h007);
        send(10'h0C0);
        reset = 1'b1;
        clear_model();
        tick();
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready",  bus.in_ready,  0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_data = 10'h3FF;
        @(negedge clk);
        check("postrst_c1_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("postrst_c2_valid", bus.out_valid, 0);
        @(negedge clk);
        check("zero_mask_valid", bus.out_valid, 1);
        check("zero_mask_data",  bus.out_data,  2'b00);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
